// File: rtl/floating_add_compare_from_int_if.sv
// ============================================================================
// Module      : floating_add_compare_from_int_if
// Description : Operand/result bundle for the single-precision add/compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface floating_add_compare_from_int_if;
  logic        enable;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic [1:0]  cmp;
  logic [31:0] debug;

  modport master (
    output enable, op, a, b,
    input  result, cmp, debug
  );

  modport slave (
    input  enable, op, a, b,
    output result, cmp, debug
  );
endinterface

`default_nettype wire

// File: rtl/floating_add_compare_from_int.sv
// ============================================================================
// Module      : floating_add_compare_from_int
// Description : IEEE-754 single add/subtract, int32-to-float and compare with
//               zero-latency outputs and enable-gated result capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module floating_add_compare_from_int (
  input  wire logic                      clk,
  input  wire logic                      reset,
  floating_add_compare_from_int_if.slave bus
);

  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_CVT = 2'b10;
  localparam logic [1:0]  OP_CMP = 2'b11;
  localparam logic [1:0]  CMP_EQ = 2'b00;
  localparam logic [1:0]  CMP_GT = 2'b01;
  localparam logic [1:0]  CMP_UN = 2'b10;
  localparam logic [1:0]  CMP_LT = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  // Operand decode; denormals are treated as zero everywhere
  logic        signA, signB, effSignB;
  logic [7:0]  expA, expB;
  logic [22:0] fracA, fracB;
  logic        zeroA, zeroB, infA, infB, nanA, nanB;
  logic [30:0] magA, magB;
  logic [23:0] mantA, mantB;

  assign signA    = bus.a[31];
  assign signB    = bus.b[31];
  assign expA     = bus.a[30:23];
  assign expB     = bus.b[30:23];
  assign fracA    = bus.a[22:0];
  assign fracB    = bus.b[22:0];
  assign effSignB = signB ^ (bus.op == OP_SUB);
  assign zeroA    = (expA == 8'd0);
  assign zeroB    = (expB == 8'd0);
  assign infA     = (expA == 8'hFF) && (fracA == 23'd0);
  assign infB     = (expB == 8'hFF) && (fracB == 23'd0);
  assign nanA     = (expA == 8'hFF) && (fracA != 23'd0);
  assign nanB     = (expB == 8'hFF) && (fracB != 23'd0);
  assign magA     = zeroA ? 31'd0 : bus.a[30:0];
  assign magB     = zeroB ? 31'd0 : bus.b[30:0];
  assign mantA    = zeroA ? 24'd0 : {1'b1, fracA};
  assign mantB    = zeroB ? 24'd0 : {1'b1, fracB};

  // Order operands by magnitude so the subtraction never goes negative
  logic        swap, sX, sY, effSub;
  logic [7:0]  eX, eY, shiftDist;
  logic [23:0] mX, mY;

  assign swap      = magB > magA;
  assign sX        = swap ? effSignB : signA;
  assign sY        = swap ? signA : effSignB;
  assign eX        = swap ? expB : expA;
  assign eY        = swap ? expA : expB;
  assign mX        = swap ? mantB : mantA;
  assign mY        = swap ? mantA : mantB;
  assign effSub    = sX ^ sY;
  assign shiftDist = eX - eY;

  // Align smaller operand, keeping guard/round/sticky
  logic [26:0] yExt, yAligned;

  always_comb begin
    yExt     = {mY, 3'b000};
    yAligned = 27'd0;
    if (shiftDist >= 8'd26) begin
      yAligned = {26'd0, |mY};
    end else begin
      yAligned    = yExt >> shiftDist;
      yAligned[0] = yAligned[0] | (|(yExt & ~({27{1'b1}} << shiftDist)));
    end
  end

  logic [27:0] rawSum;

  assign rawSum = effSub ? ({1'b0, mX, 3'b000} - {1'b0, yAligned})
                         : ({1'b0, mX, 3'b000} + {1'b0, yAligned});

  logic [4:0] sumLead, lzCount;

  always_comb begin
    sumLead = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (rawSum[i]) sumLead = i[4:0];
    end
  end

  assign lzCount = 5'd26 - sumLead;

  logic [26:0]       addNorm;
  logic signed [9:0] addExp;

  always_comb begin
    addNorm = 27'd0;
    addExp  = 10'sd0;
    if (rawSum[27]) begin
      addNorm = {rawSum[27:2], rawSum[1] | rawSum[0]};
      addExp  = $signed({2'b00, eX}) + 10'sd1;
    end else begin
      addNorm = rawSum[26:0] << lzCount;
      addExp  = $signed({2'b00, eX}) - $signed({5'd0, lzCount});
    end
  end

  // Integer conversion: left-justify the magnitude, then share the rounder
  logic [31:0]       intMag, intNormVec;
  logic [4:0]        intLead;
  logic [26:0]       cvtNorm;
  logic signed [9:0] cvtExp;

  assign intMag = bus.a[31] ? (~bus.a + 32'd1) : bus.a;

  always_comb begin
    intLead = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (intMag[i]) intLead = i[4:0];
    end
  end

  assign intNormVec = intMag << (5'd31 - intLead);
  assign cvtNorm    = {intNormVec[31:6], |intNormVec[5:0]};
  assign cvtExp     = $signed(10'd127 + {5'd0, intLead});

  // Round to nearest even
  logic              isCvt, preSign, roundUp, roundInexact;
  logic [26:0]       preNorm;
  logic signed [9:0] preExp, finalExp;
  logic [24:0]       rounded;
  logic [22:0]       finalMant;

  assign isCvt        = (bus.op == OP_CVT);
  assign preNorm      = isCvt ? cvtNorm : addNorm;
  assign preExp       = isCvt ? cvtExp : addExp;
  assign preSign      = isCvt ? bus.a[31] : sX;
  assign roundUp      = preNorm[2] & (preNorm[1] | preNorm[0] | preNorm[3]);
  assign roundInexact = |preNorm[2:0];
  assign rounded      = {1'b0, preNorm[26:3]} + {24'd0, roundUp};
  assign finalMant    = rounded[24] ? rounded[23:1] : rounded[22:0];
  assign finalExp     = rounded[24] ? (preExp + 10'sd1) : preExp;

  logic [1:0] cmpValue;

  always_comb begin
    cmpValue = CMP_EQ;
    if (nanA || nanB) begin
      cmpValue = CMP_UN;
    end else if (zeroA && zeroB) begin
      cmpValue = CMP_EQ;
    end else if (signA != signB) begin
      cmpValue = signA ? CMP_LT : CMP_GT;
    end else if (magA == magB) begin
      cmpValue = CMP_EQ;
    end else begin
      cmpValue = ((magA > magB) ^ signA) ? CMP_GT : CMP_LT;
    end
  end

  logic [31:0] rResult, calcResult;
  logic [1:0]  rCmp, calcCmp;
  logic [3:0]  rFlags, calcFlags;
  logic        fInvalid, fOverflow, fInexact, fZero;

  always_comb begin
    calcResult = rResult;
    calcCmp    = rCmp;
    fInvalid   = 1'b0;
    fOverflow  = 1'b0;
    fInexact   = 1'b0;
    fZero      = 1'b0;
    case (bus.op)
      OP_CMP: begin
        calcCmp  = cmpValue;
        fInvalid = (cmpValue == CMP_UN);
      end
      OP_CVT: begin
        if (bus.a == 32'd0) begin
          calcResult = 32'd0;
          fZero      = 1'b1;
        end else begin
          calcResult = {preSign, finalExp[7:0], finalMant};
          fInexact   = roundInexact;
        end
      end
      default: begin
        if (nanA || nanB || (infA && infB && (signA != effSignB))) begin
          calcResult = QNAN;
          fInvalid   = 1'b1;
        end else if (infA) begin
          calcResult = {signA, 8'hFF, 23'd0};
        end else if (infB) begin
          calcResult = {effSignB, 8'hFF, 23'd0};
        end else if (zeroA && zeroB) begin
          calcResult = {signA & effSignB, 31'd0};
          fZero      = 1'b1;
        end else if (rawSum == 28'd0) begin
          calcResult = 32'd0;
          fZero      = 1'b1;
        end else if (finalExp >= 10'sd255) begin
          calcResult = {sX, 8'hFF, 23'd0};
          fOverflow  = 1'b1;
          fInexact   = 1'b1;
        end else if (finalExp <= 10'sd0) begin
          // Denormal result: flush, the dropped fraction makes it inexact
          calcResult = {sX, 31'd0};
          fZero      = 1'b1;
          fInexact   = 1'b1;
        end else begin
          calcResult = {sX, finalExp[7:0], finalMant};
          fInexact   = roundInexact;
        end
      end
    endcase
  end

  assign calcFlags = {fInvalid, fOverflow, fInexact, fZero};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rResult <= 32'd0;
      rCmp    <= 2'b00;
      rFlags  <= 4'd0;
    end else if (bus.enable) begin
      rResult <= calcResult;
      rCmp    <= calcCmp;
      rFlags  <= calcFlags;
    end
  end

  // Live values while enabled; reset overrides so outputs clear at once
  assign bus.result = reset ? 32'd0 : (bus.enable ? calcResult : rResult);
  assign bus.cmp    = reset ? 2'b00 : (bus.enable ? calcCmp : rCmp);
  assign bus.debug  = reset ? 32'd0 : {28'd0, (bus.enable ? calcFlags : rFlags)};

endmodule

`default_nettype wire

// File: tb/tb_floating_add_compare_from_int.sv
// ============================================================================
// Module      : tb_floating_add_compare_from_int
// Description : Directed self-checking bench for floating_add_compare_from_int.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floating_add_compare_from_int;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  logic [31:0] heldResult;
  logic [1:0]  heldCmp;

  floating_add_compare_from_int_if bus ();

  floating_add_compare_from_int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one enabled op, check live outputs, then check they hold once enable drops
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expRes, input logic [1:0] expCmp, input logic [3:0] expFlags);
    logic [31:0] wantRes;
    logic [1:0]  wantCmp;
    wantRes = (o == 2'b11) ? heldResult : expRes;
    wantCmp = (o == 2'b11) ? expCmp : heldCmp;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.op     = o;
    bus.a      = x;
    bus.b      = y;
    #1;
    checkValue({tag, "/result"}, bus.result, wantRes);
    checkValue({tag, "/cmp"}, {30'd0, bus.cmp}, {30'd0, wantCmp});
    checkValue({tag, "/debug"}, bus.debug, {28'd0, expFlags});
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.a      = 32'h12345678;
    bus.b      = 32'h9ABCDEF0;
    #1;
    checkValue({tag, "/holdResult"}, bus.result, wantRes);
    checkValue({tag, "/holdCmp"}, {30'd0, bus.cmp}, {30'd0, wantCmp});
    checkValue({tag, "/holdDebug"}, bus.debug, {28'd0, expFlags});
    heldResult = wantRes;
    heldCmp    = wantCmp;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    heldResult = 32'd0;
    heldCmp    = 2'b00;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.op     = 2'b00;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("resetResult", bus.result, 32'd0);
    checkValue("resetCmp", {30'd0, bus.cmp}, 32'd0);
    checkValue("resetDebug", bus.debug, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //     tag          op     a             b             result        cmp    flags
    runOp("add1p2",     2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 4'h0);
    runOp("sub1m1",     2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 2'b00, 4'h1);
    runOp("subOvf",     2'b01, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 2'b00, 4'h6);
    runOp("cvt5",       2'b10, 32'd5,        32'd0,        32'h40A00000, 2'b00, 4'h0);
    runOp("cvtM1",      2'b10, 32'hFFFFFFFF, 32'd0,        32'hBF800000, 2'b00, 4'h0);
    runOp("cvtRound",   2'b10, 32'd16777217, 32'd0,        32'h4B800000, 2'b00, 4'h2);
    runOp("cvtMin",     2'b10, 32'h80000000, 32'd0,        32'hCF000000, 2'b00, 4'h0);
    runOp("cvtZero",    2'b10, 32'd0,        32'd7,        32'h00000000, 2'b00, 4'h1);
    runOp("cvtPos",     2'b10, 32'd3,        32'd0,        32'h40400000, 2'b00, 4'h0);
    runOp("cmpLt",      2'b11, 32'h3F800000, 32'h40000000, 32'h0,        2'b11, 4'h0);
    runOp("cmpGt",      2'b11, 32'h40000000, 32'h3F800000, 32'h0,        2'b01, 4'h0);
    runOp("cmpZeros",   2'b11, 32'h80000000, 32'h00000000, 32'h0,        2'b00, 4'h0);
    runOp("cmpNegs",    2'b11, 32'hC0000000, 32'hBF800000, 32'h0,        2'b11, 4'h0);
    runOp("cmpNan",     2'b11, 32'h7FC00000, 32'h3F800000, 32'h0,        2'b10, 4'h8);
    runOp("infMinusInf",2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b00, 4'h8);
    runOp("subInfInf",  2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b00, 4'h8);
    runOp("infPlusOne", 2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 2'b00, 4'h0);
    runOp("stickyOnly", 2'b00, 32'h3F800000, 32'h30800000, 32'h3F800000, 2'b00, 4'h2);
    runOp("tieEven",    2'b00, 32'h4B800000, 32'h3F800000, 32'h4B800000, 2'b00, 4'h2);
    runOp("tieOdd",     2'b00, 32'h4B800001, 32'h3F800000, 32'h4B800002, 2'b00, 4'h2);
    runOp("negZeros",   2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 2'b00, 4'h1);
    runOp("denormIn",   2'b00, 32'h00000001, 32'h80000000, 32'h00000000, 2'b00, 4'h1);
    runOp("sub1m2",     2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 2'b00, 4'h0);
    runOp("carryAdd",   2'b00, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 2'b00, 4'h0);
    runOp("nanIn",      2'b00, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b00, 4'h8);
    runOp("add1p2b",    2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 4'h0);

    // Asynchronous reset away from any clock edge
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkValue("asyncRstResult", bus.result, 32'd0);
    checkValue("asyncRstDebug", bus.debug, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("postRstResult", bus.result, 32'd0);
    checkValue("postRstCmp", {30'd0, bus.cmp}, 32'd0);
    checkValue("postRstDebug", bus.debug, 32'd0);
    heldResult = 32'd0;
    heldCmp    = 2'b00;
    runOp("afterRst",   2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 2'b00, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/floating_add_compare_from_int.md
FLOATING_ADD_COMPARE_FROM_INT -- requirements
Module: floating_add_compare_from_int

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset; clears all state.
REQ-004 enable  input  1  operation valid this cycle; result captured at the next rising clk edge.
REQ-005 op  input  2  operation select: 00 add, 01 subtract, 10 int-to-float of a, 11 compare.
REQ-006 a  input  32  IEEE-754 single operand A, or signed int32 when op=10.
REQ-007 b  input  32  IEEE-754 single operand B; ignored when op=10.
REQ-008 result  output  32  float result of add, subtract or convert.
REQ-009 cmp  output  2  compare result.
REQ-010 debug  output  32  {28'b0, invalid, overflow, inexact, zero} flags of the last operation.

Function
REQ-011 SHALL compute combinationally: while enable=1, result, cmp and debug reflect the current a, b and op in the same cycle (zero-cycle latency).
REQ-012 SHALL register the combinational values on every rising clk with enable=1; while enable=0, outputs hold the last registered values.
REQ-013 Add: a+b; subtract: a-b (b's sign inverted, then add); IEEE-754 single, round-to-nearest-even.
REQ-014 SHALL flush denormal inputs to signed zero and denormal results to signed zero; zero flag set.
REQ-015 Exact-zero sum of opposite signs SHALL give +0 (0x00000000); (-0)+(-0) SHALL give -0.
REQ-016 Exponent overflow after rounding SHALL give signed infinity (0x7F800000/0xFF800000); overflow and inexact set.
REQ-017 Inf+finite SHALL give that inf; inf-inf of same sign, or any NaN input, SHALL give 0x7FC00000 with invalid set.
REQ-018 Alignment SHALL keep guard, round and sticky bits; shift distance >=26 collapses the smaller operand to sticky only.
REQ-019 Convert: a is signed two's-complement int32; 0 -> 0x00000000; magnitudes >2^24 rounded to nearest-even; -2^31 -> 0xCF000000.
REQ-020 Compare: cmp=00 a==b (+0 equals -0), 01 a>b, 11 a<b, 10 unordered (either NaN, invalid set); result unchanged by compare.
REQ-021 In modes other than compare, cmp SHALL hold its previous value; in compare mode result SHALL hold.
REQ-022 inexact SHALL be set whenever any discarded bit is nonzero; zero flag whenever result magnitude is zero.

Reset
REQ-023 On reset assertion, immediately (asynchronously): result=0x00000000, cmp=2'b00, debug=0x00000000.
REQ-024 Reset asserted mid-operation SHALL abort capture; registered outputs stay at reset values until the first enabled edge after release.

Verification
REQ-025 op=00, a=0x3F800000, b=0x40000000, enable=1 -> result=0x40400000 same cycle, held after enable drops.
REQ-026 op=01, a=b=0x3F800000 -> result=0x00000000, zero=1; a=0x7F7FFFFF, b=0xFF7FFFFF -> result=0x7F800000, overflow=1.
REQ-027 op=10, a=5 -> 0x40A00000; a=0xFFFFFFFF -> 0xBF800000; a=16777217 -> 0x4B800000, inexact=1.
REQ-028 op=11: a=0x3F800000, b=0x40000000 -> cmp=11; swap -> 01; a=0x80000000, b=0 -> 00; a=0x7FC00000 -> 10.
REQ-029 op=00, a=0x7F800000, b=0xFF800000 -> result=0x7FC00000, invalid=1.
REQ-030 Assert reset after a captured add -> outputs 0 without a clock edge; enable=0 after release -> outputs remain 0.
